// File: rtl/conv2_post.sv
// conv2_post: per-channel bias, ReLU, 8-bit requantize and 2x2 max pool.
// Define CONV2_POOL_EN to build the pooling stage; otherwise q passes through.
module conv2_post #(
  parameter int ROWS       = 30,
  parameter int COLS       = 42,
  parameter int BIAS_SHIFT = 9,
  parameter int OUT_SHIFT  = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [479:0] conv_in,
  input  logic         conv_valid,
  input  logic         b_en,
  input  logic [7:0]   b_in,
  output logic [127:0] pool_out,
  output logic         pool_valid,
  output logic         frame_done,
  output logic         bias_ready
);
  localparam int NCH = 16;
  localparam int CW  = $clog2(COLS);
  localparam int RW  = $clog2(ROWS);

  logic [7:0]    bias_q [NCH];
  logic [3:0]    idx_q;
  logic          rdy_q;
  logic [31:0]   sum_d [NCH];
  logic [31:0]   sum_q [NCH];
  logic          s1_v_q;
  logic [31:0]   shr [NCH];
  logic [7:0]    q_d [NCH];
  logic [7:0]    q_q [NCH];
  logic          s2_v_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          last;
  logic [127:0]  pool_q;
  logic          pv_q;
  logic          fd_q;

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int n = 0; n < NCH; n++) bias_q[n] <= '0;
      idx_q <= '0;
      rdy_q <= 1'b0;
    end else if (b_en) begin
      bias_q[idx_q] <= b_in;
      idx_q         <= idx_q + 4'd1;
      if (idx_q == 4'd15) rdy_q <= 1'b1;
    end
  end

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      sum_d[n] = {{2{conv_in[30*n+29]}}, conv_in[30*n +: 30]}
               + ({{24{bias_q[n][7]}}, bias_q[n]} << BIAS_SHIFT);
    end
  end

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      shr[n] = sum_q[n] >> OUT_SHIFT;
      if (sum_q[n][31])         q_d[n] = 8'd0;
      else if (|shr[n][31:8])   q_d[n] = 8'd255;
      else                      q_d[n] = shr[n][7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= conv_valid;
      s2_v_q <= s1_v_q;
      if (conv_valid)
        for (int n = 0; n < NCH; n++) sum_q[n] <= sum_d[n];
      if (s1_v_q)
        for (int n = 0; n < NCH; n++) q_q[n] <= q_d[n];
    end
  end

  // Counters hold the map position of the q currently in stage 2
  assign last = (col_q == CW'(COLS - 1)) && (row_q == RW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (s2_v_q) begin
      if (col_q == CW'(COLS - 1)) begin
        col_q <= '0;
        row_q <= last ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

`ifdef CONV2_POOL_EN
  localparam int HW = CW - 1;

  logic [7:0]    hreg_q [NCH];
  logic [7:0]    h [NCH];
  logic [7:0]    pm [NCH];
  logic [127:0]  h_pk;
  logic [127:0]  lb_q [COLS/2];
  logic [127:0]  lb_rd;
  logic [HW-1:0] lb_a;

  assign lb_a  = col_q[CW-1:1];
  assign lb_rd = lb_q[lb_a];

  always_comb begin
    h_pk = '0;
    for (int n = 0; n < NCH; n++) begin
      h[n]  = (q_q[n] > hreg_q[n]) ? q_q[n] : hreg_q[n];
      pm[n] = (lb_rd[8*n +: 8] > h[n]) ? lb_rd[8*n +: 8] : h[n];
      h_pk[8*n +: 8] = h[n];
    end
  end

  always_ff @(posedge clk) begin
    if (s2_v_q && col_q[0] && !row_q[0]) lb_q[lb_a] <= h_pk;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int n = 0; n < NCH; n++) hreg_q[n] <= '0;
      pool_q <= '0;
      pv_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      fd_q <= 1'b0;
      if (s2_v_q) begin
        if (!col_q[0]) begin
          for (int n = 0; n < NCH; n++) hreg_q[n] <= q_q[n];
        end else if (row_q[0]) begin
          for (int n = 0; n < NCH; n++) pool_q[8*n +: 8] <= pm[n];
          pv_q <= 1'b1;
          fd_q <= last;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pool_q <= '0;
      pv_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      pv_q <= s2_v_q;
      fd_q <= s2_v_q && last;
      if (s2_v_q)
        for (int n = 0; n < NCH; n++) pool_q[8*n +: 8] <= q_q[n];
    end
  end
`endif

  assign pool_out   = pool_q;
  assign pool_valid = pv_q;
  assign frame_done = fd_q;
  assign bias_ready = rdy_q;
endmodule

// File: tb/tb_conv2_post.sv
// tb_conv2_post: random frames checked against an arithmetic reference model.
// Follows CONV2_POOL_EN the same way the design does.
module tb_conv2_post;
  localparam int ROWS = 30;
  localparam int COLS = 42;
`ifdef CONV2_POOL_EN
  localparam int NOUT = (ROWS / 2) * (COLS / 2);
`else
  localparam int NOUT = ROWS * COLS;
`endif

  typedef struct {
    logic [127:0] d;
    bit           fd;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [479:0] conv_in = '0;
  logic         conv_valid = 1'b0;
  logic         b_en = 1'b0;
  logic [7:0]   b_in = '0;
  logic [127:0] pool_out;
  logic         pool_valid;
  logic         frame_done;
  logic         bias_ready;

  int total = 0;
  int bad = 0;
  int cnt = 0;
  int nout = 0;
  int nfd = 0;

  exp_t        eq[$];
  logic [7:0]  mb [16];
  int          midx = 0;
  bit          mrdy = 1'b0;
  int          mr = 0;
  int          mc = 0;
`ifdef CONV2_POOL_EN
  logic [127:0] qmap [ROWS][COLS];
`endif

  conv2_post dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .conv_in    (conv_in),
    .conv_valid (conv_valid),
    .b_en       (b_en),
    .b_in       (b_in),
    .pool_out   (pool_out),
    .pool_valid (pool_valid),
    .frame_done (frame_done),
    .bias_ready (bias_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pool_valid) begin
      nout++;
      if (frame_done) nfd++;
      chk("out_expected", eq.size() > 0, 1'b1);
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("pool_out", pool_out, e.d);
        chk("frame_done", frame_done, e.fd);
        chk("latency", cnt, e.cyc);
      end
    end else begin
      chk("fd_idle", frame_done, 1'b0);
    end
  end

  // Reference: real arithmetic on signed values, clamp to 0..255
  function automatic logic [127:0] qvec(input logic [479:0] d);
    logic [127:0] r;
    longint s;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      s = longint'($signed(d[30*n +: 30])) + longint'($signed(mb[n])) * 512;
      if (s < 0) s = 0;
      s = s / 512;
      if (s > 255) s = 255;
      r[8*n +: 8] = 8'(s);
    end
    return r;
  endfunction

  function automatic logic [479:0] rnd();
    logic [479:0] d;
    int v;
    d = '0;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 140000));
        1:       v = -int'($urandom_range(0, 100000));
        2:       v = int'($urandom);
        default: v = int'($urandom_range(0, 2000));
      endcase
      d[30*n +: 30] = v[29:0];
    end
    return d;
  endfunction

  task automatic mbias(input logic [7:0] bv);
    mb[midx] = bv;
    if (midx == 15) mrdy = 1'b1;
    midx = (midx + 1) % 16;
  endtask

  task automatic strobe(input logic [479:0] d, input bit be,
                        input logic [7:0] bv);
    exp_t e;
    logic [127:0] qv;
    logic [7:0] m, v;
    qv = qvec(d);
    e.fd = (mr == ROWS - 1) && (mc == COLS - 1);
    e.cyc = cnt + 3;
`ifdef CONV2_POOL_EN
    qmap[mr][mc] = qv;
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      e.d = '0;
      for (int n = 0; n < 16; n++) begin
        m = 0;
        for (int k = 0; k < 4; k++) begin
          v = qmap[mr - 1 + k / 2][mc - 1 + k % 2][8*n +: 8];
          if (v > m) m = v;
        end
        e.d[8*n +: 8] = m;
      end
      eq.push_back(e);
    end
`else
    e.d = qv;
    eq.push_back(e);
`endif
    mc++;
    if (mc == COLS) begin
      mc = 0;
      mr = (mr + 1) % ROWS;
    end
    if (be) mbias(bv);
    conv_in = d;
    conv_valid = 1'b1;
    b_en = be;
    b_in = bv;
    @(posedge clk);
    #1;
    conv_valid = 1'b0;
    b_en = 1'b0;
  endtask

  task automatic bload(input logic [7:0] bv);
    mbias(bv);
    b_en = 1'b1;
    b_in = bv;
    @(posedge clk);
    #1;
    b_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int n = 0; n < 16; n++) mb[n] = '0;
    midx = 0;
    mrdy = 1'b0;
    mr = 0;
    mc = 0;
    chk("rst_pool_out", pool_out, '0);
    chk("rst_pool_valid", pool_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_bias_ready", bias_ready, 1'b0);
  endtask

  task automatic end_frame(input string tag, input int o0, input int f0);
    idle(6);
    chk({tag, "_nout"}, nout - o0, NOUT);
    chk({tag, "_nfd"}, nfd - f0, 1);
    chk({tag, "_qleft"}, eq.size(), 0);
    chk({tag, "_ready"}, bias_ready, mrdy);
  endtask

  initial begin
    int o0, f0;
    logic [479:0] d;
    for (int n = 0; n < 16; n++) mb[n] = '0;
    idle(2);
    do_reset();

    for (int n = 0; n < 15; n++) bload(8'(n + 1));
    chk("ready_at15", bias_ready, 1'b0);
    bload(8'd16);
    chk("ready_at16", bias_ready, 1'b1);

    // Frame A: zero data, output equals bias
    o0 = nout; f0 = nfd;
    for (int i = 0; i < ROWS * COLS; i++) strobe('0, 1'b0, 8'd0);
    end_frame("A", o0, f0);

    // Frame B: directed ReLU / saturation / first-window cases
    for (int n = 0; n < 16; n++)
      bload((n == 1) ? 8'hff : (n == 0 || n == 5) ? 8'd0 : 8'($urandom));
    o0 = nout; f0 = nfd;
    for (int i = 0; i < ROWS * COLS; i++) begin
      d = rnd();
      if (i == 0) begin
        d[29:0] = 30'd512;
        d[59:30] = 30'd256;
        d[5*30 +: 30] = 30'h1000_0000;
      end
      if (i == 1)  d[29:0] = 30'd1536;
      if (i == 42) d[29:0] = 30'd2048;
      if (i == 43) d[29:0] = 30'd1024;
      strobe(d, 1'b0, 8'd0);
      if (i == 43) begin
`ifdef CONV2_POOL_EN
        @(negedge clk);
        chk("win_lat0", pool_valid, 1'b0);
        @(negedge clk);
        chk("win_lat1", pool_valid, 1'b0);
        @(negedge clk);
        chk("win_pv", pool_valid, 1'b1);
        chk("win_ch0", pool_out[7:0], 8'd4);
`else
        repeat (3) @(negedge clk);
        chk("win_pv", pool_valid, 1'b1);
        chk("win_ch0", pool_out[7:0], 8'd2);
`endif
        @(posedge clk);
        #1;
      end
      if (i > 43 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    end_frame("B", o0, f0);

    // Frame C: reset after 500 strobes, then full frame with zero bias
    for (int i = 0; i < 500; i++) strobe(rnd(), 1'b0, 8'd0);
    idle(5);
    do_reset();
    o0 = nout; f0 = nfd;
    for (int i = 0; i < ROWS * COLS; i++) strobe(rnd(), 1'b0, 8'd0);
    end_frame("C", o0, f0);
    for (int n = 0; n < 16; n++) begin
      chk("reload_ready", bias_ready, 1'b0);
      bload(8'($urandom));
    end
    chk("reload_done", bias_ready, 1'b1);

    // Frame D: bias writes coincide with the first 16 strobes
    o0 = nout; f0 = nfd;
    for (int i = 0; i < ROWS * COLS; i++) begin
      strobe(rnd(), i < 16, 8'($urandom));
      if (i >= 16 && $urandom_range(0, 4) == 0) idle(1);
    end
    end_frame("D", o0, f0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
